// File: rtl/calc_exec_core_if.sv
// Instruction and TX byte-stream bundle between the switch front end, the
// calculator execution core and the UART transmitter.
interface calc_exec_core_if #(
    parameter int DATA_W = 8,
    parameter int NREG   = 4
);
    localparam int REG_AW = $clog2(NREG);
    localparam int INST_W = 2 + 3 * REG_AW;

    logic [INST_W-1:0] inst_wd;
    logic              inst_vld;
    logic              inst_rdy;
    logic              inst_drop;
    logic [7:0]        tx_data;
    logic              tx_vld;
    logic              tx_rdy;
    logic [DATA_W-1:0] result;
    logic              ovf;
    logic              done;

    // Front end side: issues instructions and applies TX backpressure.
    modport master (
        output inst_wd, inst_vld, tx_rdy,
        input  inst_rdy, inst_drop, tx_data, tx_vld, result, ovf, done
    );

    // Core side.
    modport slave (
        input  inst_wd, inst_vld, tx_rdy,
        output inst_rdy, inst_drop, tx_data, tx_vld, result, ovf, done
    );
endinterface

// File: rtl/calc_exec_core.sv
// Calculator execution core: runs one PUSH/ADD/MULT/SEND instruction at a
// time against an NREG x DATA_W register file and serialises SEND output as
// hex ASCII (with CR LF) or raw bytes over a valid/ready stream.
module calc_exec_core #(
    parameter int DATA_W   = 8,
    parameter int NREG     = 4,
    parameter int SEND_FMT = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    calc_exec_core_if.slave bus
);
    localparam int REG_AW = $clog2(NREG);
    localparam int INST_W = 2 + 3 * REG_AW;
    localparam int IMM_W  = 2 * REG_AW;
    localparam int NCH    = (DATA_W + 3) / 4;
    localparam int NBY    = (DATA_W + 7) / 8;
    // Shift register is byte-rounded; the message is left-aligned in it so
    // the next unit to send always sits at the top.
    localparam int SH_W   = 8 * NBY;
    localparam int UNIT_W = (SEND_FMT == 1) ? 8 : 4;
    localparam int NUNITS = (SEND_FMT == 1) ? NBY : NCH;
    localparam int PAD    = SH_W - UNIT_W * NUNITS;
    localparam int CNT_W  = $clog2(NUNITS) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_EXEC, S_LOAD, S_BYTE, S_CR, S_LF
    } state_e;

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00, OP_ADD = 2'b01, OP_MULT = 2'b10, OP_SEND = 2'b11
    } op_e;

    state_e              state_q, state_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic [DATA_W-1:0]   regs_q [NREG];
    logic [DATA_W-1:0]   regs_d [NREG];
    logic [DATA_W-1:0]   result_q, result_d;
    logic                ovf_q, ovf_d;
    logic [SH_W-1:0]     shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_vld_q, tx_vld_d;
    logic                done_q, done_d;
    logic                inst_drop_q, inst_drop_d;

    // Decoded fields of the latched instruction and of the incoming word.
    op_e                 op;
    op_e                 in_op;
    logic [REG_AW-1:0]   ra, rb, rc;
    logic [IMM_W-1:0]    imm;
    logic [DATA_W-1:0]   op_b, op_c;
    logic [DATA_W:0]     sum;
    logic [2*DATA_W-1:0] prod;
    logic [SH_W-1:0]     ld;

    assign op    = op_e'(inst_q[INST_W-1 -: 2]);
    assign in_op = op_e'(bus.inst_wd[INST_W-1 -: 2]);
    assign ra    = inst_q[3*REG_AW-1 -: REG_AW];
    assign rb    = inst_q[2*REG_AW-1 -: REG_AW];
    assign rc    = inst_q[REG_AW-1:0];
    assign imm   = inst_q[IMM_W-1:0];
    assign op_b  = regs_q[rb];
    assign op_c  = regs_q[rc];
    assign sum   = {1'b0, op_b} + {1'b0, op_c};
    assign prod  = (2*DATA_W)'(op_b) * (2*DATA_W)'(op_c);
    assign ld    = SH_W'(regs_q[ra]) << PAD;

    // Top unit of a left-aligned message as the byte to put on the wire.
    function automatic logic [7:0] enc_unit(input logic [SH_W-1:0] v);
        logic [3:0] nib;
        nib = v[SH_W-1 -: 4];
        if (SEND_FMT == 1) return v[SH_W-1 -: 8];
        else if (nib < 4'd10) return 8'h30 + {4'h0, nib};
        else return 8'h37 + {4'h0, nib};
    endfunction

    // Next-state and datapath logic for the instruction FSM.
    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        inst_d      = inst_q;
        regs_d      = regs_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        tx_data_d   = tx_data_q;
        tx_vld_d    = tx_vld_q;
        done_d      = 1'b0;
        inst_drop_d = bus.inst_vld && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (bus.inst_vld) begin
                    inst_d = bus.inst_wd;
                    if (in_op == OP_SEND) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_EXEC;
                        done_d  = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                case (op)
                    OP_PUSH: begin
                        regs_d[ra] = DATA_W'(imm);
                        result_d   = DATA_W'(imm);
                    end
                    OP_ADD: begin
                        regs_d[ra] = sum[DATA_W-1:0];
                        result_d   = sum[DATA_W-1:0];
                        ovf_d      = sum[DATA_W];
                    end
                    OP_MULT: begin
                        regs_d[ra] = prod[DATA_W-1:0];
                        result_d   = prod[DATA_W-1:0];
                        ovf_d      = |prod[2*DATA_W-1:DATA_W];
                    end
                    default: ;
                endcase
                state_d = S_IDLE;
            end
            S_LOAD: begin
                tx_data_d = enc_unit(ld);
                tx_vld_d  = 1'b1;
                shift_d   = ld << UNIT_W;
                cnt_d     = CNT_W'(NUNITS - 1);
                state_d   = S_BYTE;
            end
            S_BYTE: begin
                if (bus.tx_rdy) begin
                    if (cnt_q != '0) begin
                        tx_data_d = enc_unit(shift_q);
                        shift_d   = shift_q << UNIT_W;
                        cnt_d     = cnt_q - CNT_W'(1);
                    end else if (SEND_FMT == 0) begin
                        tx_data_d = 8'h0D;
                        state_d   = S_CR;
                    end else begin
                        tx_vld_d = 1'b0;
                        done_d   = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            end
            S_CR: begin
                if (bus.tx_rdy) begin
                    tx_data_d = 8'h0A;
                    state_d   = S_LF;
                end
            end
            S_LF: begin
                if (bus.tx_rdy) begin
                    tx_vld_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, register file and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            inst_q      <= '0;
            // NOTE: the register file must read zero after reset, so it is reset here rather than left as plain memory.
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            tx_data_q   <= '0;
            tx_vld_q    <= 1'b0;
            done_q      <= 1'b0;
            inst_drop_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            inst_q      <= inst_d;
            regs_q      <= regs_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            tx_data_q   <= tx_data_d;
            tx_vld_q    <= tx_vld_d;
            done_q      <= done_d;
            inst_drop_q <= inst_drop_d;
        end
    end

    assign bus.inst_rdy  = (state_q == S_IDLE);
    assign bus.inst_drop = inst_drop_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_vld    = tx_vld_q;
    assign bus.result    = result_q;
    assign bus.ovf       = ovf_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_calc_exec_core.sv
// Directed bench for calc_exec_core: an 8-bit hex-format core and a 16-bit
// raw-format core, driven through the bus interface with hand-computed values.
module tb_calc_exec_core;
    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    calc_exec_core_if #(.DATA_W(8),  .NREG(4)) if8 ();
    calc_exec_core_if #(.DATA_W(16), .NREG(4)) if16 ();

    calc_exec_core #(.DATA_W(8), .NREG(4), .SEND_FMT(0)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(if8.slave)
    );
    calc_exec_core #(.DATA_W(16), .NREG(4), .SEND_FMT(1)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(if16.slave)
    );

    typedef struct packed {
        logic        inst_rdy;
        logic        inst_drop;
        logic        tx_vld;
        logic        tx_rdy;
        logic        done;
        logic        ovf;
        logic [7:0]  tx_data;
        logic [31:0] result;
    } obs_t;

    function automatic obs_t get(input bit sel);
        obs_t o;
        if (sel) begin
            o.inst_rdy = if16.inst_rdy; o.inst_drop = if16.inst_drop;
            o.tx_vld = if16.tx_vld; o.tx_rdy = if16.tx_rdy; o.done = if16.done;
            o.ovf = if16.ovf; o.tx_data = if16.tx_data; o.result = 32'(if16.result);
        end else begin
            o.inst_rdy = if8.inst_rdy; o.inst_drop = if8.inst_drop;
            o.tx_vld = if8.tx_vld; o.tx_rdy = if8.tx_rdy; o.done = if8.done;
            o.ovf = if8.ovf; o.tx_data = if8.tx_data; o.result = 32'(if8.result);
        end
        return o;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic vld, input logic [7:0] wd);
        if (sel) begin if16.inst_vld = vld; if16.inst_wd = wd; end
        else     begin if8.inst_vld  = vld; if8.inst_wd  = wd; end
    endtask

    task automatic check_reset(input bit sel, input string tag);
        obs_t o;
        o = get(sel);
        check({tag, "_inst_rdy"},  32'(o.inst_rdy),  32'd1);
        check({tag, "_result"},    o.result,         32'd0);
        check({tag, "_ovf"},       32'(o.ovf),       32'd0);
        check({tag, "_tx_vld"},    32'(o.tx_vld),    32'd0);
        check({tag, "_tx_data"},   32'(o.tx_data),   32'd0);
        check({tag, "_done"},      32'(o.done),      32'd0);
        check({tag, "_inst_drop"}, 32'(o.inst_drop), 32'd0);
    endtask

    // Waits (bounded) for inst_rdy, then presents one instruction for one edge.
    task automatic issue(input bit sel, input logic [1:0] op, input logic [1:0] ra,
                         input logic [1:0] rb, input logic [1:0] rc);
        int n = 0;
        @(negedge clk);
        while (!get(sel).inst_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("issue_rdy", 32'(get(sel).inst_rdy), 32'd1);
        drive(sel, 1'b1, {op, ra, rb, rc});
        @(posedge clk);
        #1 drive(sel, 1'b0, {op, ra, rb, rc});
    endtask

    task automatic exec(input bit sel, input logic [1:0] op, input logic [1:0] ra,
                        input logic [1:0] rb, input logic [1:0] rc,
                        input logic [31:0] exp_res, input logic exp_ovf, input string tag);
        issue(sel, op, ra, rb, rc);
        @(negedge clk);
        check({tag, "_done"}, 32'(get(sel).done), 32'd1);
        check({tag, "_busy"}, 32'(get(sel).inst_rdy), 32'd0);
        @(negedge clk);
        check({tag, "_result"}, get(sel).result, exp_res);
        check({tag, "_ovf"}, 32'(get(sel).ovf), 32'(exp_ovf));
        check({tag, "_done_clr"}, 32'(get(sel).done), 32'd0);
    endtask

    task automatic push(input bit sel, input logic [1:0] ra, input logic [3:0] imm,
                        input logic exp_ovf, input string tag);
        exec(sel, 2'b00, ra, imm[3:2], imm[1:0], 32'(imm), exp_ovf, tag);
    endtask

    // Called at a negedge; records n transfers (MSB-first in exp) and checks done after the last.
    task automatic collect(input bit sel, input int n, input logic [31:0] exp, input string tag);
        int   k = 0;
        int   cyc = 0;
        obs_t o;
        while (k < n && cyc < 64) begin
            o = get(sel);
            if (o.tx_vld && o.tx_rdy) begin
                check($sformatf("%s_b%0d", tag, k), 32'(o.tx_data), 32'(8'(exp >> (8 * (n - 1 - k)))));
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "_nbytes"}, 32'(k), 32'(n));
        o = get(sel);
        check({tag, "_done"}, 32'(o.done), 32'd1);
        check({tag, "_vld_off"}, 32'(o.tx_vld), 32'd0);
    endtask

    task automatic send(input bit sel, input logic [1:0] ra, input int n,
                        input logic [31:0] exp, input string tag);
        issue(sel, 2'b11, ra, 2'd0, 2'd0);
        @(negedge clk);
        collect(sel, n, exp, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        if8.inst_vld = 1'b0;  if8.inst_wd = '0;  if8.tx_rdy = 1'b1;
        if16.inst_vld = 1'b0; if16.inst_wd = '0; if16.tx_rdy = 1'b1;
        #12;
        check_reset(0, "rst8");
        check_reset(1, "rst16");
        #8 rst_n = 1'b1;

        // 1: PUSH r0=2, r1=2, r2=1; MULT r0=r1*r2; SEND r2
        push(0, 2'd0, 4'h2, 1'b0, "t1_push_r0");
        push(0, 2'd1, 4'h2, 1'b0, "t1_push_r1");
        push(0, 2'd2, 4'h1, 1'b0, "t1_push_r2");
        exec(0, 2'b10, 2'd0, 2'd1, 2'd2, 32'h02, 1'b0, "t1_mult");
        send(0, 2'd2, 4, 32'h30310D0A, "t1_send_r2");
        check("t1_result_kept", get(0).result, 32'h02);

        // 2: ADD r2=r0+r3; SEND r0; SEND r3
        exec(0, 2'b01, 2'd2, 2'd0, 2'd3, 32'h02, 1'b0, "t2_add");
        send(0, 2'd0, 4, 32'h30320D0A, "t2_send_r0");
        send(0, 2'd3, 4, 32'h30300D0A, "t2_send_r3");

        // 3: PUSH r0=F, r1=F; MULT r2=r0*r1; ADD r3=r2+r2 (carry out); SEND r3
        push(0, 2'd0, 4'hF, 1'b0, "t3_push_r0");
        push(0, 2'd1, 4'hF, 1'b0, "t3_push_r1");
        exec(0, 2'b10, 2'd2, 2'd0, 2'd1, 32'hE1, 1'b0, "t3_mult");
        exec(0, 2'b01, 2'd3, 2'd2, 2'd2, 32'hC2, 1'b1, "t3_add");
        send(0, 2'd3, 4, 32'h43320D0A, "t3_send_r3");
        check("t3_result_kept", get(0).result, 32'hC2);
        check("t3_ovf_kept", 32'(get(0).ovf), 32'd1);

        // 4: SEND r2 with tx_rdy low for 5 cycles and a dropped PUSH r2=0
        if8.tx_rdy = 1'b0;
        issue(0, 2'b11, 2'd2, 2'd0, 2'd0);
        n = 0;
        @(negedge clk);
        while (!if8.tx_vld && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t4_vld_up", 32'(if8.tx_vld), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_hold_data_%0d", i), 32'(if8.tx_data), 32'h45);
            check($sformatf("t4_hold_vld_%0d", i), 32'(if8.tx_vld), 32'd1);
            check($sformatf("t4_busy_%0d", i), 32'(if8.inst_rdy), 32'd0);
            check($sformatf("t4_drop_%0d", i), 32'(if8.inst_drop), 32'(i == 2));
            if (i == 1) drive(0, 1'b1, {2'b00, 2'd2, 2'd0, 2'd0});
            else        drive(0, 1'b0, 8'h00);
            @(negedge clk);
        end
        if8.tx_rdy = 1'b1;
        collect(0, 4, 32'h45310D0A, "t4_send_r2");
        // r2 must still be E1: E1*0F = 0D2F
        exec(0, 2'b10, 2'd1, 2'd2, 2'd0, 32'h2F, 1'b1, "t4_mult_ovf");
        push(0, 2'd0, 4'h5, 1'b1, "t4_push_keeps_ovf");
        exec(0, 2'b01, 2'd0, 2'd0, 2'd0, 32'h0A, 1'b0, "t4_add_self");

        // 5: reset during the 2nd byte of SEND r3
        issue(0, 2'b11, 2'd3, 2'd0, 2'd0);
        @(negedge clk);
        @(negedge clk);
        check("t5_byte0", 32'(if8.tx_data), 32'h43);
        @(negedge clk);
        check("t5_byte1", 32'(if8.tx_data), 32'h32);
        check("t5_vld_before", 32'(if8.tx_vld), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_vld_async", 32'(if8.tx_vld), 32'd0);
        check_reset(0, "t5_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 2'd0, 4, 32'h30300D0A, "t5_r0");
        send(0, 2'd1, 4, 32'h30300D0A, "t5_r1");
        send(0, 2'd2, 4, 32'h30300D0A, "t5_r2");
        send(0, 2'd3, 4, 32'h30300D0A, "t5_r3");

        // 6: 16-bit raw core: PUSH r0=F, r1=F; MULT r2; SEND r2 -> 00 E1
        push(1, 2'd0, 4'hF, 1'b0, "t6_push_r0");
        push(1, 2'd1, 4'hF, 1'b0, "t6_push_r1");
        exec(1, 2'b10, 2'd2, 2'd0, 2'd1, 32'h00E1, 1'b0, "t6_mult");
        send(1, 2'd2, 2, 32'h000000E1, "t6_send_r2");
        exec(1, 2'b01, 2'd3, 2'd2, 2'd2, 32'h01C2, 1'b0, "t6_add_wide");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
